// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: the 4-bit operation code type, the operation
// encodings understood by `alu`, and a bundled request record.
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0000;
  localparam alu_op_t ALU_SUB = 4'b0001;
  localparam alu_op_t ALU_SLL = 4'b0010;
  localparam alu_op_t ALU_SLT = 4'b0100;
  localparam alu_op_t ALU_XOR = 4'b0110;
  localparam alu_op_t ALU_SRL = 4'b1010;
  localparam alu_op_t ALU_SRA = 4'b1011;

  // Native datapath width of the request record below.
  localparam int ALU_W = 32;

  typedef struct packed {
    alu_op_t          op;
    logic [ALU_W-1:0] in0;
    logic [ALU_W-1:0] in1;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational integer ALU.
// Ports:
//   op     - operation code (alu_op_t)
//   in0    - operand 0
//   in1    - operand 1 (low log2(N_BITS) bits give the shift amount)
//   result - operation result; encodings outside the set produce zero
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  alu_op_t           op,
  input  logic [N_BITS-1:0] in0,
  input  logic [N_BITS-1:0] in1,
  output logic [N_BITS-1:0] result
);

  localparam int SH_W = $clog2(N_BITS);

  logic [SH_W-1:0] shamt_s;

  assign shamt_s = in1[SH_W-1:0];

  // Operation decode and evaluation
  always_comb begin
    result = {N_BITS{1'b0}};
    case (op)
      ALU_ADD: result = in0 + in1;
      ALU_SUB: result = in0 - in1;
      ALU_SLL: result = in0 << shamt_s;
      ALU_SLT: result = {{(N_BITS-1){1'b0}}, ($signed(in0) < $signed(in1))};
      ALU_XOR: result = in0 ^ in1;
      ALU_SRL: result = in0 >> shamt_s;
      ALU_SRA: result = $unsigned($signed(in0) >>> shamt_s);
      default: result = {N_BITS{1'b0}};
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin scan: picks the first set request bit starting
// at `ptr` and moving upward, wrapping past N-1 back to 0.
// Ports:
//   req     - request vector
//   ptr     - index where the scan starts (highest priority)
//   grant   - one-hot grant, zero when no request is set
//   gnt_idx - index of the granted bit (zero when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] gnt_idx
);

  // Priority scan from ptr with wrap-around
  always_comb begin
    logic            found_s;
    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] idx_s;
    grant   = {N{1'b0}};
    gnt_idx = {ID_W{1'b0}};
    found_s = 1'b0;
    sum_s   = {(ID_W+1){1'b0}};
    idx_s   = {ID_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr + i cannot overflow before the wrap.
      sum_s = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum_s >= (ID_W+1)'(N)) begin
        sum_s = sum_s - (ID_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[ID_W-1:0];
      if (!found_s && req[idx_s]) begin
        found_s       = 1'b1;
        grant[idx_s]  = 1'b1;
        gnt_idx       = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Shares one combinational ALU between N_REQ requesters. A round-robin
// grant loads an issue register (ISS) that drives the ALU; the result is
// captured in a response register (RSP) held until its owner accepts it.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req_valid  - per-requester request valid
//   req_ready  - per-requester request accept (at most one bit set)
//   req_op     - packed ops, requester i in [4i+3:4i]
//   req_in0    - packed operand 0, requester i in [N_BITS*i +: N_BITS]
//   req_in1    - packed operand 1, same packing
//   rsp_valid  - one-hot owner of the pending result, or zero
//   rsp_ready  - per-requester response accept (non-owners ignored)
//   rsp_data   - pending result, shared by all requesters
//   issue_cnt  - number of accepted requests, wraps at 2^32
// ---------------------------------------------------------------------------
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int N_BITS = 32,
  parameter  int N_REQ  = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [4*N_REQ-1:0]      req_op,
  input  logic [N_BITS*N_REQ-1:0] req_in0,
  input  logic [N_BITS*N_REQ-1:0] req_in1,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [N_BITS-1:0]       rsp_data,
  output logic [31:0]             issue_cnt
);

  // Issue stage
  logic              iss_v_r;
  alu_op_t           iss_op_r;
  logic [N_BITS-1:0] iss_in0_r;
  logic [N_BITS-1:0] iss_in1_r;
  logic [ID_W-1:0]   iss_id_r;

  // Response stage
  logic              rsp_v_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [N_BITS-1:0] rsp_data_r;

  logic [ID_W-1:0]   rr_ptr_r;
  logic [31:0]       issue_cnt_r;

  logic [N_REQ-1:0]  grant_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [ID_W-1:0]   rr_next_s;
  logic              rsp_fire_s;
  logic              rsp_free_s;
  logic              iss_adv_s;
  logic              iss_free_s;
  logic              accept_s;
  alu_op_t           sel_op_s;
  logic [N_BITS-1:0] sel_in0_s;
  logic [N_BITS-1:0] sel_in1_s;
  logic [N_BITS-1:0] alu_res_s;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .grant   (grant_s),
    .gnt_idx (gnt_idx_s)
  );

  alu #(
    .N_BITS (N_BITS)
  ) u_alu (
    .op     (iss_op_r),
    .in0    (iss_in0_r),
    .in1    (iss_in1_r),
    .result (alu_res_s)
  );

  // Pipeline flow control: a stage may take new data when it is empty or
  // is handing its content onward in the same cycle.
  assign rsp_fire_s = rsp_v_r & rsp_ready[rsp_id_r];
  assign rsp_free_s = ~rsp_v_r | rsp_fire_s;
  assign iss_adv_s  = iss_v_r & rsp_free_s;
  assign iss_free_s = ~iss_v_r | iss_adv_s;

  // Gated with rst so no requester sees an accept while reset is applied.
  assign req_ready  = grant_s & {N_REQ{iss_free_s & ~rst}};
  assign accept_s   = |(req_valid & req_ready);

  assign rsp_data   = rsp_data_r;
  assign issue_cnt  = issue_cnt_r;

  // Response owner decode
  always_comb begin
    rsp_valid = {N_REQ{1'b0}};
    if (rsp_v_r) begin
      rsp_valid[rsp_id_r] = 1'b1;
    end else begin
      rsp_valid = {N_REQ{1'b0}};
    end
  end

  // Granted requester's fields, selected with constant part-selects
  always_comb begin
    sel_op_s  = ALU_ADD;
    sel_in0_s = {N_BITS{1'b0}};
    sel_in1_s = {N_BITS{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx_s == ID_W'(i)) begin
        sel_op_s  = req_op[4*i +: 4];
        sel_in0_s = req_in0[N_BITS*i +: N_BITS];
        sel_in1_s = req_in1[N_BITS*i +: N_BITS];
      end else begin
        sel_op_s  = sel_op_s;
        sel_in0_s = sel_in0_s;
        sel_in1_s = sel_in1_s;
      end
    end
  end

  // Pointer value following the current grant, modulo N_REQ
  always_comb begin
    rr_next_s = {ID_W{1'b0}};
    if (gnt_idx_s == ID_W'(N_REQ-1)) begin
      rr_next_s = {ID_W{1'b0}};
    end else begin
      rr_next_s = gnt_idx_s + ID_W'(1);
    end
  end

  // Issue stage, arbitration pointer and accept counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_r     <= 1'b0;
      iss_op_r    <= ALU_ADD;
      iss_in0_r   <= {N_BITS{1'b0}};
      iss_in1_r   <= {N_BITS{1'b0}};
      iss_id_r    <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
      issue_cnt_r <= 32'd0;
    end else begin
      if (accept_s) begin
        iss_v_r     <= 1'b1;
        iss_op_r    <= sel_op_s;
        iss_in0_r   <= sel_in0_s;
        iss_in1_r   <= sel_in1_s;
        iss_id_r    <= gnt_idx_s;
        rr_ptr_r    <= rr_next_s;
        issue_cnt_r <= issue_cnt_r + 32'd1;
      end else if (iss_adv_s) begin
        iss_v_r <= 1'b0;
      end
    end
  end

  // Response stage: capture on advance, clear when drained with no refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_v_r    <= 1'b0;
      rsp_id_r   <= {ID_W{1'b0}};
      rsp_data_r <= {N_BITS{1'b0}};
    end else begin
      if (iss_adv_s) begin
        rsp_v_r    <= 1'b1;
        rsp_id_r   <= iss_id_r;
        rsp_data_r <= alu_res_s;
      end else if (rsp_fire_s) begin
        rsp_v_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational `alu` instance between N_REQ requesters, for example the execute stage, address generation and a debug/CSR path.
- Each requester uses a valid/ready request channel (op plus two operands) and gets back a valid/ready response channel.
- A round-robin grant feeds a two-stage pipeline: an issue register drives the ALU, and a response register holds the result until the owning requester accepts it.

Parameters:
- N_BITS, 32, operand/result width.
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), requester index width (derived; not overridden).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept.
- req_op  in  4*N_REQ  alu_op of requester i in bits [4i+3:4i].
- req_in0  in  N_BITS*N_REQ  operand 0 of requester i in bits [N_BITS*i +: N_BITS].
- req_in1  in  N_BITS*N_REQ  operand 1, same packing.
- rsp_valid  out  N_REQ  one-hot or zero; the bit set is the owner of the pending result.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_data  out  N_BITS  result of the pending response; shared bus.
- issue_cnt  out  32  count of accepted requests; wraps at 2^32.

Behaviour:
- Reset (async, rst=1): the following are all cleared.
  - Issue-stage valid, response valid, rr_ptr, issue_cnt.
  - req_ready=0, rsp_valid=0, rsp_data=0.
- On deassertion: the first grant candidate is requester 0.
- Stages:
  - ISS: registers op, in0, in1, id and valid.
  - RSP: registers result, id and valid.
- The ALU is driven combinationally from ISS registers only.
- Handshakes:
  - rsp_fire = rsp_valid[rsp_id] & rsp_ready[rsp_id].
  - rsp_free = !rsp_v | rsp_fire.
  - iss_adv = iss_v & rsp_free.
  - iss_free = !iss_v | iss_adv.
- Arbitration (combinational):
  - grant = first set bit of req_valid scanning from rr_ptr upward, wrapping.
  - req_ready = grant masked by iss_free, so at most one bit is set.
  - req_ready does not depend on req_valid of other requesters beyond the grant scan.
- Accept, when req_valid[g] & req_ready[g]:
  - ISS loads requester g's fields; iss_v=1.
  - rr_ptr <= (g+1) mod N_REQ.
  - issue_cnt increments.
- No accept: rr_ptr holds.
- iss_adv: RSP loads the ALU result and iss_id; rsp_v=1. If there is no new accept the same cycle, iss_v=0.
- rsp_fire without iss_adv: rsp_v=0.
- Latency:
  - Accept at edge T; response visible after edge T+1 when unstalled.
  - Throughput is one operation per cycle with continuous rsp_ready.
- Back-pressure:
  - RSP held and not accepted → ISS holds.
  - ISS held → all req_ready=0.
  - All pending data is stable while stalled.
- Simultaneous fire/advance/accept: all three occur in one cycle with no bubble.
- A requester may have multiple results in flight. Its responses return in its acceptance order, because the pipeline is in-order.
- Requester rules:
  - A requester holds req_* stable while valid and not ready.
  - It must not depend on req_ready before asserting valid.
- rsp_valid for a non-owner is always 0. rsp_ready of non-owners is ignored.
- req_op values outside the ALU's encoding set are passed through unchanged; the result is whatever the alu produces.
- Reset mid-operation: in-flight ISS/RSP contents are discarded; no response is emitted after reset.

Decomposition:
- Shared package `alu_pkg`:
  - alu_op_t (4-bit).
  - Constants ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SLL=4'b0010, ALU_SLT=4'b0100, ALU_XOR=4'b0110, ALU_SRL=4'b1010, ALU_SRA=4'b1011.
  - Typedef alu_req_t {op, in0, in1}.
- Sub-module `rr_arbiter` (params N; ports req, ptr, grant, gnt_idx) holds the pure combinational round-robin scan.
- The existing `alu` is instantiated unmodified.

Test Plan:
- Single op: requester 2 sends ALU_ADD in0=5 in1=7 with rsp_ready=1. → rsp_valid=4'b0100 and rsp_data=12 two edges after accept; issue_cnt=1.
- Fairness: all four requesters hold valid continuously with rsp_ready=1. → Grants cycle 0,1,2,3,0,1 and each requester gets exactly 1 of every 4 accepts.
- Back-pressure: requester 0 issues ALU_SUB 10-3 with rsp_ready[0]=0 for 5 cycles while requester 1 requests.
  - rsp_data=7 is held and stable.
  - Requester 1 is accepted once into ISS, then req_ready=0.
  - On release, 7 drains, then requester 1's result follows the next cycle.
- Full throughput: requester 3 issues 8 back-to-back ALU_XOR ops with rsp_ready=1. → 8 consecutive response cycles with no bubble, in order.
- Reset mid-flight: assert rst with ISS and RSP both valid. → rsp_valid=0 and req_ready=0 immediately (async). After release, the first grant goes to requester 0 and issue_cnt=0.
- Wrap/ptr: only requester 3 is valid, then only requester 0. → rr_ptr wraps 3→0 and requester 0 is granted the next cycle.
